// File: rtl/tq_pkg.sv
// tq_pkg: shared constants, MF table, state and position-class types for tq_quant4x4.
package tq_pkg;
    localparam int QBITS_BASE = 15;
    localparam int QDIV_MAX = 8;
    // Rounding offsets at the largest qbits; smaller qbits are exact right shifts of these.
    localparam int F_INTRA = (1 << (QBITS_BASE + QDIV_MAX)) / 3;
    localparam int F_INTER = (1 << (QBITS_BASE + QDIV_MAX)) / 6;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} tq_q_state_e;
    typedef enum logic [1:0] {CLS_A, CLS_B, CLS_C} tq_cls_e;
    localparam logic [13:0] MF_TAB [6][3] = '{
        '{14'd13107, 14'd5243, 14'd8066},
        '{14'd11916, 14'd4660, 14'd7490},
        '{14'd10082, 14'd4194, 14'd6554},
        '{14'd9362,  14'd3647, 14'd5825},
        '{14'd8192,  14'd3355, 14'd5243},
        '{14'd7282,  14'd2893, 14'd4559}
    };
    function automatic tq_cls_e pos_class(input logic [3:0] idx);
        return (!idx[2] && !idx[0]) ? CLS_A : (idx[2] && idx[0]) ? CLS_B : CLS_C;
    endfunction
endpackage

// File: rtl/tq_quant4x4_if.sv
// tq_quant4x4_if: block control, coefficient input and level output signals of the quantizer.
interface tq_quant4x4_if #(parameter int COEF_W = 16, parameter int LVL_W = 16);
    logic                     blk_start_i;
    logic [3:0]               qp_div6_i;
    logic [2:0]               qp_mod6_i;
    logic                     intra_i;
    logic                     coef_valid_i;
    logic                     coef_ready_o;
    logic signed [COEF_W-1:0] coef_i;
    logic                     lvl_valid_o;
    logic                     lvl_ready_i;
    logic signed [LVL_W-1:0]  lvl_o;
    logic [3:0]               lvl_idx_o;
    logic                     lvl_last_o;
    logic [4:0]               nnz_o;
    logic                     nnz_valid_o;
    modport master (
        output blk_start_i, qp_div6_i, qp_mod6_i, intra_i, coef_valid_i, coef_i, lvl_ready_i,
        input  coef_ready_o, lvl_valid_o, lvl_o, lvl_idx_o, lvl_last_o, nnz_o, nnz_valid_o
    );
    modport slave (
        input  blk_start_i, qp_div6_i, qp_mod6_i, intra_i, coef_valid_i, coef_i, lvl_ready_i,
        output coef_ready_o, lvl_valid_o, lvl_o, lvl_idx_o, lvl_last_o, nnz_o, nnz_valid_o
    );
endinterface

// File: rtl/tq_mf_lut.sv
// tq_mf_lut: multiplication factor for a QP remainder and coefficient position class.
module tq_mf_lut import tq_pkg::*; (
    input  logic [2:0]  qp_mod6,
    input  tq_cls_e     cls,
    output logic [13:0] mf
);
    always_comb mf = MF_TAB[qp_mod6 > 3'd5 ? 3'd0 : qp_mod6][cls];
endmodule

// File: rtl/tq_quant4x4.sv
// tq_quant4x4: two-stage forward quantizer for one 4x4 block of coefficients in raster order,
// with a per-block nonzero level count.
module tq_quant4x4 import tq_pkg::*; #(
    parameter int COEF_W = 16,
    parameter int LVL_W = 16
) (
    input logic         clk,
    input logic         rst_n,
    tq_quant4x4_if.slave bus
);
    localparam int PW = COEF_W + 14;
    localparam int SW = COEF_W + 15;
    localparam logic [SW-1:0] LMAX = SW'((64'd1 << (LVL_W - 1)) - 64'd1);
    tq_q_state_e state, state_nx;
    logic [3:0] qdiv, cnt, s1_idx;
    logic [2:0] qmod;
    logic intra, advance, start_ok, coef_fire, lvl_fire, s1_valid, s1_neg;
    logic [COEF_W-1:0] mag_in;
    logic [13:0] mf;
    logic [PW-1:0] s1_prod;
    logic [4:0] qbits;
    logic [SW-1:0] f, sum, mag_out;
    logic [LVL_W-1:0] sat, lvl_nx;
    assign advance = !bus.lvl_valid_o || bus.lvl_ready_i;
    assign start_ok = state == IDLE && bus.blk_start_i;
    assign coef_fire = bus.coef_valid_i && bus.coef_ready_o;
    assign lvl_fire = bus.lvl_valid_o && bus.lvl_ready_i;
    assign mag_in = bus.coef_i[COEF_W-1] ? -bus.coef_i : bus.coef_i;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    always_comb begin
        state_nx = state == IDLE  ? (bus.blk_start_i ? BUSY : IDLE) :
                   state == BUSY  ? (coef_fire && cnt == 4'd15 ? DRAIN : BUSY) :
                   state == DRAIN ? (lvl_fire && bus.lvl_last_o ? DONE : DRAIN) : IDLE;
    end
    always_comb begin
        bus.coef_ready_o = advance && state == BUSY;
        bus.nnz_valid_o = state == DONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qdiv <= '0;
            qmod <= '0;
            intra <= 1'b0;
            cnt <= '0;
            bus.nnz_o <= '0;
        end else begin
            if (start_ok) begin
                qdiv <= bus.qp_div6_i > 4'(QDIV_MAX) ? 4'(QDIV_MAX) : bus.qp_div6_i;
                qmod <= bus.qp_mod6_i > 3'd5 ? 3'd0 : bus.qp_mod6_i;
                intra <= bus.intra_i;
                cnt <= '0;
            end else if (coef_fire) cnt <= cnt + 4'd1;
            bus.nnz_o <= start_ok ? 5'd0 : bus.nnz_o + 5'(lvl_fire && bus.lvl_o != '0);
        end
    end
    tq_mf_lut u_mf (.qp_mod6(qmod), .cls(pos_class(cnt)), .mf(mf));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_neg <= 1'b0;
            s1_idx <= '0;
            s1_prod <= '0;
        end else if (advance) begin
            s1_valid <= coef_fire;
            if (coef_fire) begin
                s1_prod <= PW'(mag_in) * PW'(mf);
                s1_neg <= bus.coef_i[COEF_W-1];
                s1_idx <= cnt;
            end
        end
    end
    always_comb begin
        qbits = 5'(QBITS_BASE) + 5'(qdiv);
        f = (intra ? SW'(F_INTRA) : SW'(F_INTER)) >> (4'(QDIV_MAX) - qdiv);
        sum = {1'b0, s1_prod} + f;
        mag_out = sum >> qbits;
        sat = LVL_W'(mag_out > LMAX ? LMAX : mag_out);
        lvl_nx = s1_neg ? -sat : sat;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.lvl_valid_o <= 1'b0;
            bus.lvl_o <= '0;
            bus.lvl_idx_o <= '0;
            bus.lvl_last_o <= 1'b0;
        end else if (advance) begin
            bus.lvl_valid_o <= s1_valid;
            if (s1_valid) begin
                bus.lvl_o <= lvl_nx;
                bus.lvl_idx_o <= s1_idx;
                bus.lvl_last_o <= s1_idx == 4'd15;
            end
        end
    end
endmodule

// File: tb/tb_tq_quant4x4.sv
// tb_tq_quant4x4: directed vectors for tq_quant4x4; a 12-bit-level twin runs in lockstep
// to cover output saturation.
module tb_tq_quant4x4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    tq_quant4x4_if #(.COEF_W(16), .LVL_W(16)) b ();
    tq_quant4x4_if #(.COEF_W(16), .LVL_W(12)) b12 ();
    assign b12.blk_start_i = b.blk_start_i;
    assign b12.qp_div6_i = b.qp_div6_i;
    assign b12.qp_mod6_i = b.qp_mod6_i;
    assign b12.intra_i = b.intra_i;
    assign b12.coef_valid_i = b.coef_valid_i;
    assign b12.coef_i = b.coef_i;
    assign b12.lvl_ready_i = b.lvl_ready_i;
    tq_quant4x4 #(.COEF_W(16), .LVL_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    tq_quant4x4 #(.COEF_W(16), .LVL_W(12)) dut12 (.clk(clk), .rst_n(rst_n), .bus(b12));
    typedef struct {
        logic [3:0] qdiv;
        logic [2:0] qmod;
        logic       intra;
        int         idx;
        int         coef;
        int         e16;
        int         e12;
    } vec_t;
    vec_t tv[12];
    int n_checks = 0, n_fail = 0;
    logic signed [15:0] coefs[16];
    int got16[16], got12[16];
    int order_err, last_err, hold_err, ready_err, stall_vcyc, timeout, nnz_got, nnzv_seen;
    int pat[16] = '{20, 12, 20, 12, 12, 8, 12, 8, 20, 12, 20, 12, 12, 8, 12, 8};
    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic to_idle();
        b.blk_start_i = 1'b0;
        @(posedge clk); #1;
    endtask
    // Returns in the cycle after the last level handshake, where the count pulse is expected.
    task automatic run_block(input logic do_start, input logic [3:0] qd, input logic [2:0] qm,
                             input logic it, input int stall_at, input int stall_len, input int bad_at);
        int sent, nout, cyc, stalled;
        logic signed [15:0] held_l;
        logic [3:0] held_i;
        sent = 0; nout = 0; cyc = 0; stalled = 0; held_l = '0; held_i = '0;
        order_err = 0; last_err = 0; hold_err = 0; ready_err = 0; stall_vcyc = 0; timeout = 0;
        for (int i = 0; i < 16; i++) begin got16[i] = -99999; got12[i] = -99999; end
        if (do_start) begin
            b.qp_div6_i = qd; b.qp_mod6_i = qm; b.intra_i = it; b.blk_start_i = 1'b1;
            @(posedge clk); #1;
            b.blk_start_i = 1'b0;
        end
        while (nout < 16 && cyc < 300) begin
            if (bad_at >= 0 && sent == bad_at) begin
                b.blk_start_i = 1'b1; b.qp_div6_i = 4'd4; b.qp_mod6_i = 3'd4; b.intra_i = 1'b0;
            end else b.blk_start_i = 1'b0;
            b.lvl_ready_i = !(stall_at >= 0 && nout >= stall_at && stalled < stall_len);
            b.coef_valid_i = sent < 16;
            b.coef_i = sent < 16 ? coefs[sent] : 16'sd0;
            #1;
            if (!b.lvl_ready_i) begin
                if (b.lvl_valid_o) begin
                    stall_vcyc++;
                    if (b.coef_ready_o) ready_err++;
                    if (stalled > 0 && (b.lvl_o !== held_l || b.lvl_idx_o !== held_i)) hold_err++;
                    held_l = b.lvl_o; held_i = b.lvl_idx_o;
                end
                stalled++;
            end
            if (b.coef_valid_i && b.coef_ready_o) sent++;
            if (b12.lvl_valid_o && b12.lvl_ready_i) got12[b12.lvl_idx_o] = int'(b12.lvl_o);
            if (b.lvl_valid_o && b.lvl_ready_i) begin
                if (int'(b.lvl_idx_o) != nout) order_err++;
                if (b.lvl_last_o != (b.lvl_idx_o == 4'd15)) last_err++;
                got16[b.lvl_idx_o] = int'(b.lvl_o);
                nout++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        b.coef_valid_i = 1'b0; b.blk_start_i = 1'b0; b.lvl_ready_i = 1'b1;
        timeout = cyc >= 300;
        nnzv_seen = b.nnz_valid_o;
        nnz_got = b.nnz_o;
    endtask
    initial begin
        int nz, lv, cr;
        tv[0]  = '{4'd0,  3'd0, 1'b1, 0,  -50,    -20,    -20};
        tv[1]  = '{4'd0,  3'd0, 1'b1, 5,  50,     8,      8};
        tv[2]  = '{4'd4,  3'd4, 1'b1, 0,  100,    1,      1};
        tv[3]  = '{4'd4,  3'd4, 1'b0, 0,  100,    1,      1};
        tv[4]  = '{4'd0,  3'd0, 1'b1, 0,  -32768, -13107, -2047};
        tv[5]  = '{4'd0,  3'd7, 1'b1, 0,  -50,    -20,    -20};
        tv[6]  = '{4'd0,  3'd0, 1'b0, 1,  1000,   246,    246};
        tv[7]  = '{4'd12, 3'd2, 1'b1, 0,  32767,  39,     39};
        tv[8]  = '{4'd1,  3'd3, 1'b0, 15, -7000,  -389,   -389};
        tv[9]  = '{4'd2,  3'd5, 1'b1, 10, 9,      0,      0};
        tv[10] = '{4'd0,  3'd0, 1'b1, 0,  32767,  13106,  2047};
        tv[11] = '{4'd0,  3'd0, 1'b1, 6,  -3,     -1,     -1};
        b.blk_start_i = 1'b0; b.qp_div6_i = '0; b.qp_mod6_i = '0; b.intra_i = 1'b0;
        b.coef_valid_i = 1'b0; b.coef_i = '0; b.lvl_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_outputs", {b.lvl_valid_o, b.lvl_o, b.lvl_idx_o, b.lvl_last_o, b.coef_ready_o,
                                b.nnz_o, b.nnz_valid_o}, 0);
        for (int v = 0; v < 12; v++) begin
            for (int i = 0; i < 16; i++) coefs[i] = '0;
            coefs[tv[v].idx] = 16'(tv[v].coef);
            run_block(1'b1, tv[v].qdiv, tv[v].qmod, tv[v].intra, -1, 0, -1);
            nz = 0;
            for (int i = 0; i < 16; i++) if (i != tv[v].idx && got16[i] != 0) nz++;
            check($sformatf("v%0d_level", v), got16[tv[v].idx], tv[v].e16);
            check($sformatf("v%0d_level12", v), got12[tv[v].idx], tv[v].e12);
            check($sformatf("v%0d_other_nonzero", v), nz, 0);
            check($sformatf("v%0d_order", v), order_err + last_err, 0);
            check($sformatf("v%0d_nnz", v), nnz_got, tv[v].e16 != 0);
            check($sformatf("v%0d_nnz_valid", v), nnzv_seen, 1);
            check($sformatf("v%0d_timeout", v), timeout, 0);
            to_idle();
        end
        // Full block of 50s with a 5-cycle output stall after the sixth level.
        for (int i = 0; i < 16; i++) coefs[i] = 16'sd50;
        run_block(1'b1, 4'd0, 3'd0, 1'b1, 6, 5, -1);
        for (int i = 0; i < 16; i++) check($sformatf("bp_level%0d", i), got16[i], pat[i]);
        check("bp_order", order_err, 0);
        check("bp_last", last_err, 0);
        check("bp_hold", hold_err, 0);
        check("bp_ready_drop", ready_err, 0);
        check("bp_stall_cycles", stall_vcyc, 5);
        check("bp_nnz", nnz_got, 16);
        check("bp_nnz_valid", nnzv_seen, 1);
        to_idle();
        check("nnz_held_idle", b.nnz_o, 16);
        check("nnz_valid_one_cycle", b.nnz_valid_o, 0);
        // Start pulse during BUSY must not reload the QP parameters.
        for (int i = 0; i < 16; i++) coefs[i] = '0;
        coefs[12] = -16'sd50;
        run_block(1'b1, 4'd0, 3'd0, 1'b1, -1, 0, 3);
        check("busy_start_level", got16[12], -12);
        check("busy_start_nnz", nnz_got, 1);
        check("busy_start_timeout", timeout, 0);
        // Start during DONE is ignored; the one in the following IDLE cycle is accepted.
        b.qp_div6_i = 4'd0; b.qp_mod6_i = 3'd0; b.intra_i = 1'b1; b.blk_start_i = 1'b1;
        @(posedge clk); #1;
        check("done_start_ignored", b.coef_ready_o, 0);
        @(posedge clk); #1;
        b.blk_start_i = 1'b0;
        check("b2b_accept", b.coef_ready_o, 1);
        for (int i = 0; i < 16; i++) coefs[i] = '0;
        coefs[5] = 16'sd50;
        run_block(1'b0, 4'd0, 3'd0, 1'b1, -1, 0, -1);
        check("b2b_level", got16[5], 8);
        check("b2b_nnz", nnz_got, 1);
        to_idle();
        // Reset after the idx-7 input handshake aborts the block.
        for (int i = 0; i < 16; i++) coefs[i] = 16'sd50;
        b.qp_div6_i = 4'd0; b.qp_mod6_i = 3'd0; b.intra_i = 1'b1; b.blk_start_i = 1'b1;
        @(posedge clk); #1;
        b.blk_start_i = 1'b0;
        nz = 0;
        for (int c = 0; c < 40 && nz < 8; c++) begin
            b.coef_valid_i = 1'b1; b.coef_i = coefs[nz];
            #1;
            if (b.coef_ready_o) nz++;
            @(posedge clk); #1;
        end
        check("rst_reached_idx7", nz, 8);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {b.lvl_valid_o, b.lvl_o, b.lvl_idx_o, b.lvl_last_o, b.coef_ready_o,
                              b.nnz_o, b.nnz_valid_o}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        lv = 0; cr = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (b.lvl_valid_o) lv++;
            if (b.coef_ready_o) cr++;
        end
        b.coef_valid_i = 1'b0;
        check("rst_no_stale_levels", lv, 0);
        check("rst_stays_idle", cr, 0);
        for (int i = 0; i < 16; i++) coefs[i] = '0;
        coefs[0] = -16'sd50;
        run_block(1'b1, 4'd0, 3'd0, 1'b1, -1, 0, -1);
        check("rst_recover_level", got16[0], -20);
        check("rst_recover_nnz", nnz_got, 1);
        to_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tq_quant4x4.md
# tq_quant4x4

Forward quantizer for the transform/quant path. It accepts one 4x4 block of signed DCT coefficients, streamed one per cycle in raster order, under a valid/ready handshake. Each coefficient is scaled by an H.264-style multiplication factor selected by the QP remainder and the coefficient position, then shifted by 15 plus the QP quotient. Quantized levels stream out to the entropy coder with a per-block nonzero count.

## Interface
- COEF_W, 16, signed input coefficient width
- LVL_W, 16, signed output level width; results saturate symmetrically to ±(2^(LVL_W-1)-1)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- blk_start_i  in  1  one-cycle pulse that starts a block; honoured only in IDLE
- qp_div6_i  in  4  QP quotient, latched on an accepted blk_start_i; values above 8 clamp to 8
- qp_mod6_i  in  3  QP remainder, latched on an accepted blk_start_i; values 6 and 7 are treated as 0
- intra_i  in  1  rounding mode, latched on an accepted blk_start_i; 1 = intra (f = 2^qbits/3), 0 = inter (f = 2^qbits/6)
- coef_valid_i  in  1  coefficient valid
- coef_ready_o  out  1  coefficient ready
- coef_i  in  COEF_W  signed coefficient
- lvl_valid_o  out  1  level valid
- lvl_ready_i  in  1  level ready
- lvl_o  out  LVL_W  signed quantized level
- lvl_idx_o  out  4  raster index of the level, 0..15
- lvl_last_o  out  1  high with index 15
- nnz_o  out  5  count of nonzero levels in the block, 0..16
- nnz_valid_o  out  1  one-cycle pulse; nnz_o is valid while it is high

## Operation
- FSM states: IDLE, BUSY, DRAIN, DONE.
  - IDLE to BUSY on blk_start_i. This latches the QP and intra inputs and clears the input counter and nnz.
  - BUSY to DRAIN after the 16th input handshake.
  - DRAIN to DONE on the output handshake with lvl_last_o.
  - DONE to IDLE unconditionally.
  - blk_start_i is ignored in any state other than IDLE.
- Position class is taken from index i: row = i[3:2], col = i[1:0].
  - Class A: row and col both even.
  - Class B: row and col both odd.
  - Class C: all other positions.
- MF table, listed as A/B/C for qp_mod6 = 0..5:
  - 0: 13107/5243/8066
  - 1: 11916/4660/7490
  - 2: 10082/4194/6554
  - 3: 9362/3647/5825
  - 4: 8192/3355/5243
  - 5: 7282/2893/4559
- Arithmetic:
  - qbits = 15 + qp_div6.
  - level = sign(coef) * ((|coef| * MF + f) >> qbits), then saturate to LVL_W.
  - |coef| is COEF_W bits unsigned, so |-2^(COEF_W-1)| is representable.
  - The sum is held in COEF_W + 14 + 1 bits with no overflow.
- nnz increments on each output handshake where lvl_o != 0. It is presented at the DONE pulse and held until the next accepted blk_start_i.

## Timing
- Two-stage pipeline:
  - S1 registers |coef| * MF, the sign, and the index.
  - S2 registers the rounded, shifted, sign-restored and saturated level into the lvl_* outputs.
- Latency: 2 cycles from the input handshake to lvl_valid_o, with no backpressure.
- Global stall: advance = !lvl_valid_o || lvl_ready_i, and coef_ready_o = advance && state == BUSY. S1 and S2 hold their contents when advance is 0. Throughput is 1 level per cycle.
- Handshake rules:
  - Once lvl_valid_o is high, lvl_o, lvl_idx_o and lvl_last_o stay stable until lvl_ready_i is seen.
  - coef_valid_i may stay high across IDLE without being consumed.
- nnz_valid_o is high for exactly one cycle (the DONE state), in the cycle after the last output handshake.
- The earliest next block can start 2 cycles after the last output handshake: one cycle in DONE, then blk_start_i accepted in IDLE.
- Reset values: all outputs 0, state IDLE, pipeline valids 0.
  - Asserting rst_n low mid-block aborts the block immediately.
  - After release the block waits in IDLE and emits no stale levels.

## Structure
- Package tq_pkg holds:
  - the MF table (6x3 localparam)
  - QBITS_BASE = 15
  - QDIV_MAX = 8
  - the state enum tq_q_state_e
- Sub-module tq_mf_lut is combinational: (qp_mod6, class) to a 14-bit MF. It is instantiated once in S1.

## Test plan
- Intra, qp_div6 = 0, qp_mod6 = 0:
  - coef -50 at idx 0 gives lvl -20.
  - coef 50 at idx 5 gives lvl 8.
  - coef 0 elsewhere gives lvl 0.
  - nnz_o = 2 at the pulse.
- Intra, qp_div6 = 4, qp_mod6 = 4: coef 100 at idx 0 gives lvl 1. Inter with the same inputs gives lvl 1 (offset 87381).
- Boundaries:
  - coef -32768 at idx 0, qp 0 intra, LVL_W = 16 gives -13107.
  - The same input with LVL_W = 12 gives -2047 (saturated).
  - qp_mod6 = 7 behaves exactly like qp_mod6 = 0.
- Backpressure:
  - Hold lvl_ready_i = 0 for 5 cycles mid-block. coef_ready_o must drop and outputs must hold.
  - All 16 levels must arrive in index order with lvl_last_o only on idx 15.
- Start and reset:
  - blk_start_i during BUSY is ignored, so parameters stay unchanged.
  - Back-to-back blocks: the second blk_start_i is accepted 2 cycles after the last handshake.
  - rst_n low at idx 7 gives all outputs 0, then IDLE with no output until a new start.
